// File: rtl/inertial_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : inertial_pkg
//  Description : Shared types and constants for the IMU producer interface:
//                FSM state encodings, IMU init command words, read register
//                addresses and a helper that builds read command words.
//  Revision    : 1.0 - initial release
// ============================================================================
package inertial_pkg;

   // Top-level sequencing states
   typedef enum logic [3:0] {
      ST_INIT_WAIT = 4'd0,
      ST_INIT1     = 4'd1,
      ST_INIT2     = 4'd2,
      ST_INIT3     = 4'd3,
      ST_INIT4     = 4'd4,
      ST_IDLE      = 4'd5,
      ST_RD_PL     = 4'd6,
      ST_RD_PH     = 4'd7,
      ST_RD_AL     = 4'd8,
      ST_RD_AH     = 4'd9,
      ST_VLD       = 4'd10
   } imu_state_e;

   // SPI transaction engine states
   typedef enum logic [1:0] {
      SPI_IDLE        = 2'd0,
      SPI_FRONT_PORCH = 2'd1,
      SPI_SHIFT       = 2'd2,
      SPI_BACK_PORCH  = 2'd3
   } spi_state_e;

   // IMU configuration writes, issued in this order after power-up
   localparam logic [15:0] CMD_INT_EN    = 16'h0D02;  // data-ready interrupt enable
   localparam logic [15:0] CMD_ACCEL_CFG = 16'h1160;  // accel ODR / range
   localparam logic [15:0] CMD_GYRO_CFG  = 16'h1250;  // gyro ODR / range
   localparam logic [15:0] CMD_ROUNDING  = 16'h1460;  // rounding

   // Data registers read on every interrupt
   localparam logic [6:0] ADDR_PITCH_L = 7'h22;
   localparam logic [6:0] ADDR_PITCH_H = 7'h23;
   localparam logic [6:0] ADDR_AZ_L    = 7'h2C;
   localparam logic [6:0] ADDR_AZ_H    = 7'h2D;

   // Command bit 15: 1 = read, 0 = write
   localparam logic READ_BIT = 1'b1;

   // Read command word; the data byte is don't-care for reads, sent as zero
   function automatic logic [15:0] rd_cmd(input logic [6:0] addr);
      return {READ_BIT, addr, 8'h00};
   endfunction

endpackage
`default_nettype wire

// File: rtl/inertial_intf_spi_mnrch.sv
`default_nettype none
// ============================================================================
//  Module      : spi_mnrch
//  Description : 16-bit SPI master, mode 3 (SCLK idles high). MOSI changes on
//                SCLK falling edges, MISO is sampled on rising edges. SS_n
//                frames each transaction; done pulses as SS_n rises.
//  Revision    : 1.0 - initial release
// ============================================================================
module spi_mnrch
   import inertial_pkg::*;
#(
   parameter int SCLK_DIV_W = 4
)
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        wrt,
   input  logic [15:0] cmd,
   output logic        done,
   output logic [15:0] resp,
   output logic        SS_n,
   output logic        SCLK,
   output logic        MOSI,
   input  logic        MISO
);

   // SCLK is the divider MSB: all-ones -> 0 is a falling edge, and
   // 0111.. -> 1000.. is a rising edge, so both edges are predictable
   // one clk ahead from the divider value.
   localparam logic [SCLK_DIV_W-1:0] DIV_ALL_ONES = '1;
   localparam logic [SCLK_DIV_W-1:0] DIV_MID      = {1'b1, {(SCLK_DIV_W-1){1'b0}}};
   localparam logic [SCLK_DIV_W-1:0] DIV_PRE_RISE = {1'b0, {(SCLK_DIV_W-1){1'b1}}};
   localparam logic [SCLK_DIV_W-1:0] DIV_ONE      = {{(SCLK_DIV_W-1){1'b0}}, 1'b1};

   spi_state_e              state_q, state_d;
   logic [SCLK_DIV_W-1:0]   div_q, div_d;
   logic [15:0]             shft_q, shft_d;
   logic                    miso_q, miso_d;
   logic [3:0]              bit_cnt_q, bit_cnt_d;
   logic                    ss_n_q, ss_n_d;
   logic                    done_q, done_d;

   // State and datapath registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= SPI_IDLE;
         div_q     <= DIV_ALL_ONES;
         shft_q    <= '0;
         miso_q    <= 1'b0;
         bit_cnt_q <= '0;
         ss_n_q    <= 1'b1;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         div_q     <= div_d;
         shft_q    <= shft_d;
         miso_q    <= miso_d;
         bit_cnt_q <= bit_cnt_d;
         ss_n_q    <= ss_n_d;
         done_q    <= done_d;
      end
   end

   // Next-state logic. The first falling edge (end of front porch) only
   // starts the clock; later falls shift out the next bit and shift in the
   // MISO bit captured on the preceding rise. The bit captured on the 16th
   // rise is shifted in when the back porch ends.
   always_comb begin
      state_d   = state_q;
      div_d     = div_q;
      shft_d    = shft_q;
      miso_d    = miso_q;
      bit_cnt_d = bit_cnt_q;
      ss_n_d    = ss_n_q;
      done_d    = 1'b0;
      unique case (state_q)
         SPI_IDLE: begin
            div_d = DIV_ALL_ONES;
            if (wrt) begin
               state_d   = SPI_FRONT_PORCH;
               div_d     = DIV_MID;
               shft_d    = cmd;
               bit_cnt_d = '0;
               ss_n_d    = 1'b0;
            end
         end
         SPI_FRONT_PORCH: begin
            div_d = div_q + DIV_ONE;
            if (div_q == DIV_ALL_ONES) begin
               state_d = SPI_SHIFT;
            end
         end
         SPI_SHIFT: begin
            div_d = div_q + DIV_ONE;
            if (div_q == DIV_PRE_RISE) begin
               miso_d    = MISO;
               bit_cnt_d = bit_cnt_q + 4'd1;
               if (bit_cnt_q == 4'hF) begin
                  state_d = SPI_BACK_PORCH;
               end
            end else if (div_q == DIV_ALL_ONES) begin
               shft_d = {shft_q[14:0], miso_q};
            end
         end
         SPI_BACK_PORCH: begin
            if (div_q == DIV_ALL_ONES) begin
               shft_d  = {shft_q[14:0], miso_q};
               ss_n_d  = 1'b1;
               done_d  = 1'b1;
               state_d = SPI_IDLE;
            end else begin
               div_d = div_q + DIV_ONE;
            end
         end
         default: state_d = SPI_IDLE;
      endcase
   end

   assign SCLK = div_q[SCLK_DIV_W-1];
   assign MOSI = shft_q[15];
   assign SS_n = ss_n_q;
   assign done = done_q;
   assign resp = shft_q;

endmodule
`default_nettype wire

// File: rtl/inertial_intf.sv
`default_nettype none
// ============================================================================
//  Module      : inertial_intf
//  Description : IMU producer interface. Configures the IMU after a power-up
//                wait, then on each data-ready interrupt reads pitch rate and
//                Z acceleration over SPI and presents them with a 1-clk vld.
//  Revision    : 1.0 - initial release
// ============================================================================
module inertial_intf
   import inertial_pkg::*;
#(
   parameter int INIT_WAIT_W = 16,
   parameter int SCLK_DIV_W  = 4
)
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        INT,
   input  logic        MISO,
   output logic        SS_n,
   output logic        SCLK,
   output logic        MOSI,
   output logic        vld,
   output logic [15:0] ptch_rt,
   output logic [15:0] AZ
);

   localparam logic [INIT_WAIT_W-1:0] INIT_CNT_MAX = '1;
   localparam logic [INIT_WAIT_W-1:0] INIT_CNT_ONE = {{(INIT_WAIT_W-1){1'b0}}, 1'b1};

   imu_state_e             state_q, state_d;
   logic [INIT_WAIT_W-1:0] init_cnt_q, init_cnt_d;
   logic                   int_ff1_q, int_s_q;
   logic                   wrt_q, wrt_d;
   logic [15:0]            cmd_q, cmd_d;
   logic [7:0]             ptch_lo_q, ptch_lo_d;
   logic [7:0]             ptch_hi_q, ptch_hi_d;
   logic [7:0]             az_lo_q, az_lo_d;
   logic                   vld_q, vld_d;
   logic [15:0]            ptch_rt_q, ptch_rt_d;
   logic [15:0]            az_q, az_d;

   logic                   done;
   logic [15:0]            resp;
   logic                   resp_hi_unused;

   // Only the data byte of each response carries register contents
   assign resp_hi_unused = ^resp[15:8];

   spi_mnrch #(
      .SCLK_DIV_W (SCLK_DIV_W)
   ) u_spi (
      .clk   (clk),
      .rst_n (rst_n),
      .wrt   (wrt_q),
      .cmd   (cmd_q),
      .done  (done),
      .resp  (resp),
      .SS_n  (SS_n),
      .SCLK  (SCLK),
      .MOSI  (MOSI),
      .MISO  (MISO)
   );

   // Two-flop synchronizer for the asynchronous data-ready interrupt
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         int_ff1_q <= 1'b0;
         int_s_q   <= 1'b0;
      end else begin
         int_ff1_q <= INT;
         int_s_q   <= int_ff1_q;
      end
   end

   // Sequencer state, command and captured data registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ST_INIT_WAIT;
         init_cnt_q <= '0;
         wrt_q      <= 1'b0;
         cmd_q      <= '0;
         ptch_lo_q  <= '0;
         ptch_hi_q  <= '0;
         az_lo_q    <= '0;
         vld_q      <= 1'b0;
         ptch_rt_q  <= '0;
         az_q       <= '0;
      end else begin
         state_q    <= state_d;
         init_cnt_q <= init_cnt_d;
         wrt_q      <= wrt_d;
         cmd_q      <= cmd_d;
         ptch_lo_q  <= ptch_lo_d;
         ptch_hi_q  <= ptch_hi_d;
         az_lo_q    <= az_lo_d;
         vld_q      <= vld_d;
         ptch_rt_q  <= ptch_rt_d;
         az_q       <= az_d;
      end
   end

   // Sequencer: wrt is registered, so each command goes out the cycle after
   // the done that triggered it. The result pair loads on the same edge that
   // enters VLD, making vld and new data appear together one clk after the
   // final done; VLD then idles one cycle before INT_s is looked at again.
   always_comb begin
      state_d    = state_q;
      init_cnt_d = init_cnt_q;
      wrt_d      = 1'b0;
      cmd_d      = cmd_q;
      ptch_lo_d  = ptch_lo_q;
      ptch_hi_d  = ptch_hi_q;
      az_lo_d    = az_lo_q;
      vld_d      = 1'b0;
      ptch_rt_d  = ptch_rt_q;
      az_d       = az_q;
      unique case (state_q)
         ST_INIT_WAIT: begin
            if (init_cnt_q == INIT_CNT_MAX) begin
               wrt_d   = 1'b1;
               cmd_d   = CMD_INT_EN;
               state_d = ST_INIT1;
            end else begin
               init_cnt_d = init_cnt_q + INIT_CNT_ONE;
            end
         end
         ST_INIT1: if (done) begin
            wrt_d   = 1'b1;
            cmd_d   = CMD_ACCEL_CFG;
            state_d = ST_INIT2;
         end
         ST_INIT2: if (done) begin
            wrt_d   = 1'b1;
            cmd_d   = CMD_GYRO_CFG;
            state_d = ST_INIT3;
         end
         ST_INIT3: if (done) begin
            wrt_d   = 1'b1;
            cmd_d   = CMD_ROUNDING;
            state_d = ST_INIT4;
         end
         ST_INIT4: if (done) begin
            state_d = ST_IDLE;
         end
         ST_IDLE: if (int_s_q) begin
            wrt_d   = 1'b1;
            cmd_d   = rd_cmd(ADDR_PITCH_L);
            state_d = ST_RD_PL;
         end
         ST_RD_PL: if (done) begin
            ptch_lo_d = resp[7:0];
            wrt_d     = 1'b1;
            cmd_d     = rd_cmd(ADDR_PITCH_H);
            state_d   = ST_RD_PH;
         end
         ST_RD_PH: if (done) begin
            ptch_hi_d = resp[7:0];
            wrt_d     = 1'b1;
            cmd_d     = rd_cmd(ADDR_AZ_L);
            state_d   = ST_RD_AL;
         end
         ST_RD_AL: if (done) begin
            az_lo_d = resp[7:0];
            wrt_d   = 1'b1;
            cmd_d   = rd_cmd(ADDR_AZ_H);
            state_d = ST_RD_AH;
         end
         ST_RD_AH: if (done) begin
            ptch_rt_d = {ptch_hi_q, ptch_lo_q};
            az_d      = {resp[7:0], az_lo_q};
            vld_d     = 1'b1;
            state_d   = ST_VLD;
         end
         ST_VLD: state_d = ST_IDLE;
         default: state_d = ST_INIT_WAIT;
      endcase
   end

   assign vld     = vld_q;
   assign ptch_rt = ptch_rt_q;
   assign AZ      = az_q;

endmodule
`default_nettype wire
